// File: rtl/fe_inv.sv
// Field inverter for GF(2^255-19): out = a^(P-2) by left-to-right square-and-multiply.
// Drives an external field multiplier through a start/done handshake; holds no multiplier itself.
module fe_inv #(
   parameter int NBITS = 255,
   parameter int LOGB  = 8,
   parameter logic [NBITS-1:0] E = {{(NBITS-5){1'b1}}, 5'b01011}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [NBITS-1:0] a_in,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] out,
   output logic             mul_start,
   output logic [NBITS-1:0] mul_a,
   output logic [NBITS-1:0] mul_b,
   input  logic             mul_done,
   input  logic [NBITS-1:0] mul_out
);

   typedef enum logic [2:0] {
      IDLE,
      SQ_ISSUE,
      SQ_WAIT,
      MUL_ISSUE,
      MUL_WAIT,
      FINISH
   } state_t;

   state_t           state, state_nx;
   logic [NBITS-1:0] acc, acc_nx;
   logic [NBITS-1:0] base, base_nx;
   logic [LOGB-1:0]  idx, idx_nx;
   logic             busy_nx, done_nx, mul_start_nx;
   logic [NBITS-1:0] out_nx, mul_a_nx, mul_b_nx;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         base      <= '0;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out       <= '0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         base      <= base_nx;
         idx       <= idx_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         out       <= out_nx;
         mul_start <= mul_start_nx;
         mul_a     <= mul_a_nx;
         mul_b     <= mul_b_nx;
      end
   end

   // The top exponent bit is always 1, so the accumulator starts at a and the scan begins one bit lower.
   // A start coinciding with the done pulse is refused so the finished result gets one quiet cycle.
   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      base_nx      = base;
      idx_nx       = idx;
      busy_nx      = busy;
      done_nx      = 1'b0;
      out_nx       = out;
      mul_start_nx = 1'b0;
      mul_a_nx     = mul_a;
      mul_b_nx     = mul_b;

      case (state)
         IDLE: begin
            if (start && !done) begin
               base_nx  = a_in;
               acc_nx   = a_in;
               idx_nx   = LOGB'(NBITS - 2);
               busy_nx  = 1'b1;
               state_nx = SQ_ISSUE;
            end
         end
         SQ_ISSUE: state_nx = SQ_WAIT;
         SQ_WAIT: begin
            if (mul_done) begin
               acc_nx = mul_out;
               if (E[idx]) begin
                  state_nx = MUL_ISSUE;
               end else if (idx == '0) begin
                  state_nx = FINISH;
               end else begin
                  idx_nx   = idx - LOGB'(1);
                  state_nx = SQ_ISSUE;
               end
            end
         end
         MUL_ISSUE: state_nx = MUL_WAIT;
         MUL_WAIT: begin
            if (mul_done) begin
               acc_nx = mul_out;
               if (idx == '0) begin
                  state_nx = FINISH;
               end else begin
                  idx_nx   = idx - LOGB'(1);
                  state_nx = SQ_ISSUE;
               end
            end
         end
         FINISH: begin
            out_nx   = acc;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Multiplier request is registered off the next state so it is high exactly during the ISSUE cycle.
      if (state_nx == SQ_ISSUE) begin
         mul_start_nx = 1'b1;
         mul_a_nx     = acc_nx;
         mul_b_nx     = acc_nx;
      end else if (state_nx == MUL_ISSUE) begin
         mul_start_nx = 1'b1;
         mul_a_nx     = acc_nx;
         mul_b_nx     = base_nx;
      end
   end

endmodule
